// File: rtl/sort_unloader_if.sv
// -----------------------------------------------------------------------------
// sort_unloader_if
//   Groups the signals between the bitonic sorter, the unloader and the narrow
//   downstream consumer.
//   Sort side   : y_valid, y (N lanes, lane 0 in the LSBs), in_ready
//   Stream side : m_data, m_valid, m_ready, m_last, m_index
//   master : the unloader (drives in_ready and the m_* outputs)
//   slave  : the environment (drives y_valid, y and m_ready)
//   m_index is at least 1 bit wide so that N=1 still gives a legal port; it
//   stays 0 in that case.
// -----------------------------------------------------------------------------
interface sort_unloader_if #(
   parameter int LOG_INPUT  = 5,
   parameter int DATA_WIDTH = 32
);
   localparam int N  = 1 << LOG_INPUT;
   localparam int IW = (LOG_INPUT > 0) ? LOG_INPUT : 1;

   logic                    y_valid;
   logic [DATA_WIDTH*N-1:0] y;
   logic                    in_ready;
   logic [DATA_WIDTH-1:0]   m_data;
   logic                    m_valid;
   logic                    m_ready;
   logic                    m_last;
   logic [IW-1:0]           m_index;

   modport master (
      input  y_valid, y, m_ready,
      output in_ready, m_data, m_valid, m_last, m_index
   );

   modport slave (
      output y_valid, y, m_ready,
      input  in_ready, m_data, m_valid, m_last, m_index
   );
endinterface

// File: rtl/sort_unloader.sv
// -----------------------------------------------------------------------------
// sort_unloader
//   Drains the parallel sorted vector of the bitonic sort network one word per
//   valid/ready handshake, lane 0 first, and flags vectors that arrive while a
//   previous one is still draining (they are dropped).
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   bus         sort_unloader_if.master (y_valid, y, in_ready, m_data,
//               m_valid, m_ready, m_last, m_index)
//   ovf_clr_i   synchronous clear of the sticky overflow flag
//   overflow_o  sticky: a sorted vector was dropped
// Parameters
//   LOG_INPUT    log2 of lane count N
//   DATA_WIDTH   bits per lane
//   EDGE_CAPTURE 0: capture on every y_valid&in_ready; 1: only on a y_valid rise
// -----------------------------------------------------------------------------
module sort_unloader #(
   parameter int LOG_INPUT    = 5,
   parameter int DATA_WIDTH   = 32,
   parameter int EDGE_CAPTURE = 0
) (
   input  logic             clk,
   input  logic             rst,
   sort_unloader_if.master  bus,
   input  logic             ovf_clr_i,
   output logic             overflow_o
);
   localparam int N  = 1 << LOG_INPUT;
   localparam int IW = (LOG_INPUT > 0) ? LOG_INPUT : 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] lane_q [N];
   logic                  y_valid_q;
   logic                  overflow_q, overflow_d;

   logic at_last;
   logic edge_ok;
   logic cap;
   logic ovf_ev;
   logic hs;
   logic load;

   // With N=1 idx never moves, so every word is the last one.
   assign at_last = (idx_q == IW'(N - 1));

   // Edge mode treats the cycle right after reset as an edge (y_valid_q=0).
   assign edge_ok = (EDGE_CAPTURE != 0) ? ~y_valid_q : 1'b1;

   // in_ready opens on the final handshake so a new vector follows with no bubble.
   assign bus.in_ready = (state_q == IDLE) |
                         ((state_q == STREAM) & at_last & bus.m_ready);

   assign cap        = bus.y_valid & bus.in_ready & edge_ok;
   assign ovf_ev     = bus.y_valid & ~bus.in_ready & edge_ok;
   assign hs         = bus.m_valid & bus.m_ready;
   assign overflow_o = overflow_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      load       = 1'b0;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: begin
            if (cap) begin
               load    = 1'b1;
               idx_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (hs) begin
               if (!at_last) begin
                  idx_d = idx_q + IW'(1);
               end else if (cap) begin
                  load  = 1'b1;
                  idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A new drop wins over a simultaneous clear.
      if (ovf_ev) begin
         overflow_d = 1'b1;
      end else if (ovf_clr_i) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      bus.m_valid = (state_q == STREAM);
      bus.m_data  = '0;
      bus.m_index = '0;
      bus.m_last  = 1'b0;
      if (state_q == STREAM) begin
         bus.m_data  = lane_q[idx_q];
         bus.m_index = idx_q;
         bus.m_last  = at_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         y_valid_q  <= 1'b0;
         overflow_q <= 1'b0;
         for (int i = 0; i < N; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         y_valid_q  <= bus.y_valid;
         overflow_q <= overflow_d;
         if (load) begin
            for (int i = 0; i < N; i++) begin
               lane_q[i] <= bus.y[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end
endmodule

// File: tb/tb_sort_unloader.sv
// -----------------------------------------------------------------------------
// tb_sort_unloader
//   Two instances with N=4 lanes of 32 bits: dut_a in level-capture mode is
//   checked every cycle against a word-queue reference model; dut_b in
//   edge-capture mode is checked for a single stream under a held y_valid.
// -----------------------------------------------------------------------------
module tb_sort_unloader;
   localparam int LOG = 2;
   localparam int N   = 4;
   localparam int DW  = 32;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [1:0]    idx;
      logic          last;
   } word_t;

   logic clk = 1'b0;
   logic rst;
   logic ovf_clr;
   logic ovf_a, ovf_b;

   sort_unloader_if #(.LOG_INPUT(LOG), .DATA_WIDTH(DW)) ia ();
   sort_unloader_if #(.LOG_INPUT(LOG), .DATA_WIDTH(DW)) ib ();

   sort_unloader #(.LOG_INPUT(LOG), .DATA_WIDTH(DW), .EDGE_CAPTURE(0)) dut_a (
      .clk(clk), .rst(rst), .bus(ia), .ovf_clr_i(ovf_clr), .overflow_o(ovf_a));

   sort_unloader #(.LOG_INPUT(LOG), .DATA_WIDTH(DW), .EDGE_CAPTURE(1)) dut_b (
      .clk(clk), .rst(rst), .bus(ib), .ovf_clr_i(ovf_clr), .overflow_o(ovf_b));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   word_t         mq[$];     // words the model expects dut_a to emit, in order
   logic          m_ovf;     // model overflow flag
   logic [DW-1:0] got_a[$];
   logic [DW-1:0] got_b[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW*N-1:0] pack4(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                                             input logic [DW-1:0] l2, input logic [DW-1:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // Checks that a captured word list is exactly first, first+1, ... (n words).
   task automatic chk_seq(input string tag, input logic [DW-1:0] q[$],
                          input logic [DW-1:0] first, input int n);
      chk({tag, "_count"}, 64'(q.size()), 64'(n));
      for (int i = 0; i < n && i < q.size(); i++) begin
         chk({tag, "_word"}, 64'(q[i]), 64'(first + DW'(i)));
      end
   endtask

   // One clock: check dut_a against the model on the falling edge, then
   // advance the model on the rising edge. Returns 1 time unit after the edge.
   task automatic cycle();
      logic          exp_v, exp_rdy, hs, cap, ev, clr;
      logic [DW*N-1:0] yv;
      @(negedge clk);
      exp_v   = (mq.size() > 0);
      exp_rdy = (mq.size() == 0) || (mq.size() == 1 && ia.m_ready);
      chk("m_valid", 64'(ia.m_valid), 64'(exp_v));
      chk("in_ready", 64'(ia.in_ready), 64'(exp_rdy));
      chk("overflow", 64'(ovf_a), 64'(m_ovf));
      if (exp_v) begin
         chk("m_data", 64'(ia.m_data), 64'(mq[0].d));
         chk("m_index", 64'(ia.m_index), 64'(mq[0].idx));
         chk("m_last", 64'(ia.m_last), 64'(mq[0].last));
      end else begin
         chk("m_data_idle", 64'(ia.m_data), 64'd0);
         chk("m_last_idle", 64'(ia.m_last), 64'd0);
      end
      hs  = exp_v && ia.m_ready;
      cap = ia.y_valid && exp_rdy;
      ev  = ia.y_valid && !exp_rdy;
      clr = ovf_clr;
      yv  = ia.y;
      if (ia.m_valid && ia.m_ready) got_a.push_back(ia.m_data);
      if (ib.m_valid && ib.m_ready) got_b.push_back(ib.m_data);
      @(posedge clk);
      if (hs) void'(mq.pop_front());
      if (cap) begin
         for (int i = 0; i < N; i++) begin
            mq.push_back('{d: yv[i*DW +: DW], idx: 2'(i), last: (i == N - 1)});
         end
      end
      if (ev) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      #1;
   endtask

   initial begin
      int k;
      rst        = 1'b1;
      ovf_clr    = 1'b0;
      ia.y_valid = 1'b0;
      ia.y       = '0;
      ia.m_ready = 1'b1;
      ib.y_valid = 1'b0;
      ib.y       = '0;
      ib.m_ready = 1'b1;
      m_ovf      = 1'b0;
      #3;
      chk("rst_m_valid", 64'(ia.m_valid), 64'd0);
      chk("rst_m_data", 64'(ia.m_data), 64'd0);
      chk("rst_m_last", 64'(ia.m_last), 64'd0);
      chk("rst_m_index", 64'(ia.m_index), 64'd0);
      chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
      chk("rst_overflow", 64'(ovf_a), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single vector, consumer always ready
      got_a.delete();
      ia.y = pack4(1, 2, 3, 4);
      ia.y_valid = 1'b1;
      cycle();
      ia.y_valid = 1'b0;
      chk("t1_first_word", 64'(ia.m_data), 64'd1);
      repeat (6) cycle();
      chk_seq("t1", got_a, 1, 4);
      chk("t1_in_ready", 64'(ia.in_ready), 64'd1);

      // Consumer toggling ready: each word must be held, none skipped
      got_a.delete();
      ia.y_valid = 1'b1;
      cycle();
      ia.y_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ia.m_ready = (i % 2 == 0);
         cycle();
      end
      ia.m_ready = 1'b1;
      repeat (2) cycle();
      chk_seq("t2", got_a, 1, 4);

      // Vector dropped while lane 1 is draining
      got_a.delete();
      ia.y_valid = 1'b1;
      cycle();
      ia.y_valid = 1'b0;
      cycle();
      ia.y = pack4(9, 9, 9, 9);
      ia.y_valid = 1'b1;
      cycle();
      ia.y_valid = 1'b0;
      ia.y = pack4(1, 2, 3, 4);
      chk("t3_ovf_set", 64'(ovf_a), 64'd1);
      repeat (4) cycle();
      chk_seq("t3", got_a, 1, 4);
      chk("t3_ovf_sticky", 64'(ovf_a), 64'd1);
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", 64'(ovf_a), 64'd0);

      // Back-to-back vectors: second offered on the lane-3 handshake
      got_a.delete();
      ia.y_valid = 1'b1;
      cycle();
      ia.y_valid = 1'b0;
      k = 0;
      while (mq.size() != 1 && k < 10) begin
         cycle();
         k++;
      end
      if (mq.size() != 1) chk("t4_timeout", 64'd0, 64'd1);
      ia.y = pack4(5, 6, 7, 8);
      ia.y_valid = 1'b1;
      chk("t4_in_ready", 64'(ia.in_ready), 64'd1);
      cycle();
      ia.y_valid = 1'b0;
      chk("t4_m_valid", 64'(ia.m_valid), 64'd1);
      chk("t4_m_data", 64'(ia.m_data), 64'd5);
      chk("t4_ovf", 64'(ovf_a), 64'd0);
      repeat (6) cycle();
      chk_seq("t4", got_a, 1, 8);

      // Reset mid-stream abandons the stream asynchronously
      ia.y = pack4(1, 2, 3, 4);
      ia.y_valid = 1'b1;
      cycle();
      ia.y_valid = 1'b0;
      repeat (2) cycle();
      rst = 1'b1;
      #1;
      chk("t5_m_valid", 64'(ia.m_valid), 64'd0);
      chk("t5_in_ready", 64'(ia.in_ready), 64'd1);
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      got_a.delete();
      ia.y = pack4(32'hA, 32'hB, 32'hC, 32'hD);
      ia.y_valid = 1'b1;
      cycle();
      ia.y_valid = 1'b0;
      chk("t5_m_index", 64'(ia.m_index), 64'd0);
      chk("t5_m_data", 64'(ia.m_data), 64'hA);
      repeat (5) cycle();
      chk_seq("t5", got_a, 32'hA, 4);

      // Edge-capture instance with y_valid held high
      got_b.delete();
      ib.y = pack4(11, 12, 13, 14);
      ib.y_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cycle();
         chk("t6_ovf", 64'(ovf_b), 64'd0);
      end
      ib.y_valid = 1'b0;
      repeat (2) cycle();
      chk_seq("t6", got_b, 11, 4);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         for (int l = 0; l < N; l++) ia.y[l*DW +: DW] = $urandom;
         ia.y_valid = ($urandom_range(5) == 0);
         ia.m_ready = ($urandom_range(2) != 0);
         ovf_clr    = ($urandom_range(15) == 0);
         cycle();
      end
      ia.y_valid = 1'b0;
      ia.m_ready = 1'b1;
      ovf_clr    = 1'b0;
      repeat (6) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
